// File: rtl/stage_id_if.sv
// Signal bundle between fetch/write-back/pipeline control and the decode stage.
// The slave modport is the decode stage; the master modport is everything around it.
interface stage_id_if #(
    parameter int XLEN = 64
);
    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_instr;
    logic            if_valid;
    logic            stall;
    logic            flush;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    logic            hazard_stall;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic [XLEN-1:0] id_rs1_val;
    logic [XLEN-1:0] id_rs2_val;
    logic [XLEN-1:0] id_imm;
    logic [3:0]      id_alu_op;
    logic            id_alu_src;
    logic            id_word;
    logic [2:0]      id_funct3;
    logic            id_mem_read;
    logic            id_mem_write;
    logic            id_reg_write;
    logic            id_mem_to_reg;
    logic            id_branch;
    logic            id_jump;
    logic            id_illegal;

    modport master (
        output if_pc, if_instr, if_valid, stall, flush, wb_we, wb_rd, wb_data,
        input  hazard_stall, id_valid, id_pc, id_rs1, id_rs2, id_rd,
               id_rs1_val, id_rs2_val, id_imm, id_alu_op, id_alu_src, id_word,
               id_funct3, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg,
               id_branch, id_jump, id_illegal
    );

    modport slave (
        input  if_pc, if_instr, if_valid, stall, flush, wb_we, wb_rd, wb_data,
        output hazard_stall, id_valid, id_pc, id_rs1, id_rs2, id_rd,
               id_rs1_val, id_rs2_val, id_imm, id_alu_op, id_alu_src, id_word,
               id_funct3, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg,
               id_branch, id_jump, id_illegal
    );
endinterface

// File: rtl/stage_id.sv
// RV64I decode stage: register file with write-through bypass, instruction decode,
// ID/EX pipeline register and load-use hazard detection.
module stage_id #(
    parameter int XLEN = 64
) (
    input  logic      clk,
    input  logic      rst,
    stage_id_if.slave bus
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32   = 7'b0111011;

    localparam logic [3:0] ALU_ADD = 4'd0,  ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_OR = 4'd8,   ALU_AND = 4'd9, ALU_PASS_B = 4'd10;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu_op;
        logic            alu_src;
        logic            word;
        logic [2:0]      funct3;
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
        logic            mem_to_reg;
        logic            branch;
        logic            jump;
        logic            illegal;
    } id_t;

    // funct7[5] (instr[30]) selects SUB only for register-register ops; it selects SRA for both forms.
    function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt, input logic is_reg);
        case (f3)
            3'b000:  alu_fn = (is_reg && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_fn = ALU_SLL;
            3'b010:  alu_fn = ALU_SLT;
            3'b011:  alu_fn = ALU_SLTU;
            3'b100:  alu_fn = ALU_XOR;
            3'b101:  alu_fn = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_fn = ALU_OR;
            default: alu_fn = ALU_AND;
        endcase
    endfunction

    logic [XLEN-1:0] rf_q [0:31];
    id_t             id_q;
    id_t             id_d;
    logic            rs1_used;
    logic            rs2_used;
    logic            hazard;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_rf
            always_ff @(posedge clk) begin
                if (rst || gi == 0) begin
                    rf_q[gi] <= '0;
                end else if (bus.wb_we && bus.wb_rd == 5'(gi)) begin
                    rf_q[gi] <= bus.wb_data;
                end
            end
        end
    endgenerate

    wire [31:0] instr = bus.if_instr;
    wire [6:0]  opcode = instr[6:0];
    wire [4:0]  rs1_f  = instr[19:15];
    wire [4:0]  rs2_f  = instr[24:20];

    wire [XLEN-1:0] rs1_rd = (rs1_f == 5'd0) ? '0 :
                             (bus.wb_we && bus.wb_rd == rs1_f) ? bus.wb_data : rf_q[rs1_f];
    wire [XLEN-1:0] rs2_rd = (rs2_f == 5'd0) ? '0 :
                             (bus.wb_we && bus.wb_rd == rs2_f) ? bus.wb_data : rf_q[rs2_f];

    wire [XLEN-1:0] imm_i = {{52{instr[31]}}, instr[31:20]};
    wire [XLEN-1:0] imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
    wire [XLEN-1:0] imm_b = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    wire [XLEN-1:0] imm_u = {{32{instr[31]}}, instr[31:12], 12'b0};
    wire [XLEN-1:0] imm_j = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        id_d         = '0;
        rs1_used     = 1'b1;
        rs2_used     = 1'b0;
        id_d.valid   = bus.if_valid;
        id_d.pc      = bus.if_pc;
        id_d.rs1     = rs1_f;
        id_d.rs2     = rs2_f;
        id_d.rd      = instr[11:7];
        id_d.rs1_val = rs1_rd;
        id_d.rs2_val = rs2_rd;
        id_d.funct3  = instr[14:12];
        case (opcode)
            OPC_LUI: begin
                id_d.imm = imm_u; id_d.alu_op = ALU_PASS_B; id_d.alu_src = 1'b1;
                id_d.reg_write = 1'b1; rs1_used = 1'b0;
            end
            OPC_AUIPC: begin
                id_d.imm = imm_u; id_d.alu_src = 1'b1; id_d.reg_write = 1'b1; rs1_used = 1'b0;
            end
            OPC_JAL: begin
                id_d.imm = imm_j; id_d.alu_src = 1'b1; id_d.reg_write = 1'b1;
                id_d.jump = 1'b1; rs1_used = 1'b0;
            end
            OPC_JALR: begin
                id_d.imm = imm_i; id_d.alu_src = 1'b1; id_d.reg_write = 1'b1; id_d.jump = 1'b1;
            end
            OPC_BRANCH: begin
                id_d.imm = imm_b; id_d.alu_op = ALU_SUB; id_d.branch = 1'b1;
                id_d.rd = '0; rs2_used = 1'b1;
            end
            OPC_LOAD: begin
                id_d.imm = imm_i; id_d.alu_src = 1'b1; id_d.mem_read = 1'b1;
                id_d.reg_write = 1'b1; id_d.mem_to_reg = 1'b1;
            end
            OPC_STORE: begin
                id_d.imm = imm_s; id_d.alu_src = 1'b1; id_d.mem_write = 1'b1;
                id_d.rd = '0; rs2_used = 1'b1;
            end
            OPC_OPIMM, OPC_OPIMM32: begin
                id_d.imm = imm_i; id_d.alu_op = alu_fn(instr[14:12], instr[30], 1'b0);
                id_d.alu_src = 1'b1; id_d.reg_write = 1'b1; id_d.word = (opcode == OPC_OPIMM32);
            end
            OPC_OP, OPC_OP32: begin
                id_d.alu_op = alu_fn(instr[14:12], instr[30], 1'b1);
                id_d.reg_write = 1'b1; id_d.word = (opcode == OPC_OP32); rs2_used = 1'b1;
            end
            default: begin
                id_d.illegal = 1'b1; id_d.rd = '0; id_d.funct3 = '0;
            end
        endcase
    end

    assign hazard = id_q.valid && id_q.mem_read && (id_q.rd != 5'd0) && bus.if_valid && !bus.flush &&
                    ((rs1_used && id_q.rd == rs1_f) || (rs2_used && id_q.rd == rs2_f));

    // Flush outranks stall; a load-use bubble only enters when the pipe is not held.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            id_q <= '0;
        end else if (!bus.stall) begin
            id_q <= hazard ? '0 : id_d;
        end
    end

    assign bus.hazard_stall  = hazard;
    assign bus.id_valid      = id_q.valid;
    assign bus.id_pc         = id_q.pc;
    assign bus.id_rs1        = id_q.rs1;
    assign bus.id_rs2        = id_q.rs2;
    assign bus.id_rd         = id_q.rd;
    assign bus.id_rs1_val    = id_q.rs1_val;
    assign bus.id_rs2_val    = id_q.rs2_val;
    assign bus.id_imm        = id_q.imm;
    assign bus.id_alu_op     = id_q.alu_op;
    assign bus.id_alu_src    = id_q.alu_src;
    assign bus.id_word       = id_q.word;
    assign bus.id_funct3     = id_q.funct3;
    assign bus.id_mem_read   = id_q.mem_read;
    assign bus.id_mem_write  = id_q.mem_write;
    assign bus.id_reg_write  = id_q.reg_write;
    assign bus.id_mem_to_reg = id_q.mem_to_reg;
    assign bus.id_branch     = id_q.branch;
    assign bus.id_jump       = id_q.jump;
    assign bus.id_illegal    = id_q.illegal;
endmodule

// File: tb/tb_stage_id.sv
// Directed bench for stage_id: hand-decoded instructions with expected ID/EX contents.
module tb_stage_id;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    stage_id_if bus ();

    stage_id dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic valid, input logic [63:0] pc);
        bus.if_instr = instr;
        bus.if_valid = valid;
        bus.if_pc    = pc;
    endtask

    task automatic wb(input logic we, input logic [4:0] rd, input logic [63:0] data);
        bus.wb_we   = we;
        bus.wb_rd   = rd;
        bus.wb_data = data;
    endtask

    initial begin
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        // Reset held two cycles while random traffic (including write-backs) hits the inputs.
        for (int i = 0; i < 2; i++) begin
            drive($urandom, 1'b1, {$urandom, $urandom});
            wb(1'b1, 5'($urandom), {$urandom, $urandom});
            bus.stall = 1'($urandom);
            bus.flush = 1'($urandom);
            tick();
        end
        chk("rst_valid", bus.id_valid, 0);
        chk("rst_pc", bus.id_pc, 0);
        chk("rst_imm", bus.id_imm, 0);
        chk("rst_rd", bus.id_rd, 0);
        chk("rst_regwrite", bus.id_reg_write, 0);
        chk("rst_memread", bus.id_mem_read, 0);
        chk("rst_hazard", bus.hazard_stall, 0);

        // add x3,x2,x1 right after reset: both operands read 0
        rst = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
        wb(1'b0, 5'd0, 64'd0);
        drive(32'h001101B3, 1'b1, 64'h100);
        tick();
        chk("add_valid", bus.id_valid, 1);
        chk("add_pc", bus.id_pc, 64'h100);
        chk("add_rd", bus.id_rd, 3);
        chk("add_rs1val", bus.id_rs1_val, 0);
        chk("add_rs2val", bus.id_rs2_val, 0);
        chk("add_imm", bus.id_imm, 0);
        chk("add_alusrc", bus.id_alu_src, 0);

        // addi x1,x0,5
        drive(32'h00500093, 1'b1, 64'h104);
        tick();
        chk("addi_rd", bus.id_rd, 1);
        chk("addi_imm", bus.id_imm, 5);
        chk("addi_aluop", bus.id_alu_op, 0);
        chk("addi_alusrc", bus.id_alu_src, 1);
        chk("addi_regwrite", bus.id_reg_write, 1);

        // add x3,x2,x1 with x1=0x1234 written back the same cycle
        drive(32'h001101B3, 1'b1, 64'h108);
        wb(1'b1, 5'd1, 64'h1234);
        tick();
        chk("bypass_rs2val", bus.id_rs2_val, 64'h1234);
        chk("bypass_rs1val", bus.id_rs1_val, 0);

        // sub x5,x2,x1: x1 now stored in the file
        wb(1'b0, 5'd0, 64'd0);
        drive(32'h401102B3, 1'b1, 64'h10C);
        tick();
        chk("sub_aluop", bus.id_alu_op, 1);
        chk("sub_rs2val", bus.id_rs2_val, 64'h1234);
        chk("sub_rd", bus.id_rd, 5);

        // ld x2,0(x1) then add x3,x2,x1 -> one-cycle load-use bubble
        drive(32'h0000B103, 1'b1, 64'h110);
        tick();
        chk("ld_memread", bus.id_mem_read, 1);
        chk("ld_rd", bus.id_rd, 2);
        chk("ld_funct3", bus.id_funct3, 3);
        chk("ld_memtoreg", bus.id_mem_to_reg, 1);
        chk("ld_rs1val", bus.id_rs1_val, 64'h1234);
        drive(32'h001101B3, 1'b1, 64'h114);
        #1;
        chk("lu_hazard_on", bus.hazard_stall, 1);
        tick();
        chk("lu_bubble_valid", bus.id_valid, 0);
        chk("lu_bubble_rd", bus.id_rd, 0);
        chk("lu_hazard_off", bus.hazard_stall, 0);
        tick();
        chk("lu_add_valid", bus.id_valid, 1);
        chk("lu_add_rd", bus.id_rd, 3);
        chk("lu_add_pc", bus.id_pc, 64'h114);

        // beq x0,x0,-4 then flush
        drive(32'hFE000EE3, 1'b1, 64'h118);
        tick();
        chk("beq_imm", bus.id_imm, 64'hFFFFFFFFFFFFFFFC);
        chk("beq_branch", bus.id_branch, 1);
        chk("beq_aluop", bus.id_alu_op, 1);
        chk("beq_regwrite", bus.id_reg_write, 0);
        drive(32'h00500093, 1'b1, 64'h11C);
        bus.flush = 1'b1;
        tick();
        chk("flush_valid", bus.id_valid, 0);
        chk("flush_branch", bus.id_branch, 0);
        chk("flush_regwrite", bus.id_reg_write, 0);
        bus.flush = 1'b0;

        // lui x6,0x80000 (negative U immediate), then stall holds it
        drive(32'h80000337, 1'b1, 64'h120);
        tick();
        chk("lui_imm", bus.id_imm, 64'hFFFFFFFF80000000);
        chk("lui_aluop", bus.id_alu_op, 10);
        chk("lui_rd", bus.id_rd, 6);
        drive(32'h00500093, 1'b1, 64'h124);
        bus.stall = 1'b1;
        tick();
        chk("stall_hold_imm", bus.id_imm, 64'hFFFFFFFF80000000);
        chk("stall_hold_pc", bus.id_pc, 64'h120);
        bus.flush = 1'b1;
        tick();
        chk("flush_over_stall", bus.id_valid, 0);
        bus.stall = 1'b0; bus.flush = 1'b0;

        // all-zero word is illegal; simultaneous write-back to x0 must be dropped
        drive(32'h00000000, 1'b1, 64'h128);
        wb(1'b1, 5'd0, 64'hFF);
        tick();
        chk("ill_illegal", bus.id_illegal, 1);
        chk("ill_valid", bus.id_valid, 1);
        chk("ill_memread", bus.id_mem_read, 0);
        chk("ill_regwrite", bus.id_reg_write, 0);
        chk("ill_alusrc", bus.id_alu_src, 0);
        // add x3,x0,x0 while x0 is again targeted by write-back
        drive(32'h000001B3, 1'b1, 64'h12C);
        tick();
        chk("x0_rs1val", bus.id_rs1_val, 0);
        chk("x0_rs2val", bus.id_rs2_val, 0);
        chk("x0_illegal", bus.id_illegal, 0);

        // reset mid-stream overrides a concurrent write to x1
        wb(1'b1, 5'd1, 64'hDEAD);
        rst = 1'b1;
        tick();
        chk("rst2_valid", bus.id_valid, 0);
        chk("rst2_regwrite", bus.id_reg_write, 0);
        rst = 1'b0;
        wb(1'b0, 5'd0, 64'd0);
        drive(32'h00108233, 1'b1, 64'h200);
        tick();
        chk("rst2_x1_cleared", bus.id_rs1_val, 0);
        chk("rst2_first_valid", bus.id_valid, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
